// File: rtl/conv_pkg.sv
// conv_pkg: shared types and sizing helpers for the streaming convolution engine.
//   conv_state_e : engine phase (LOAD, COMPUTE, OUTPUT)
//   acc_width()  : full-precision result width for a given sample width and length
//   num_out()    : number of results of a full linear convolution of two length-n sequences
package conv_pkg;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      COMPUTE = 2'd1,
      OUTPUT  = 2'd2
   } conv_state_e;

   function automatic int acc_width(input int data_w, input int n);
      return 2 * data_w + $clog2(n);
   endfunction

   function automatic int num_out(input int n);
      return 2 * n - 1;
   endfunction

endpackage

// File: rtl/conv_mac.sv
// conv_mac: registered multiply-accumulate used by conv_stream_engine.
//   clk, rst  : clock, synchronous active-high reset (accumulator -> 0)
//   clr       : load zero into the accumulator (wins over en)
//   en        : accumulator update enable
//   add_en    : when enabled, add a*b; otherwise hold the current value
//   a, b      : DATA_W-bit operands
//   acc_sum   : value the accumulator takes on the coming edge
// Build option: CONV_SIGNED_EN makes a and b two's complement and sign-extends
// the product; without it the product is unsigned and zero-extended.
module conv_mac import conv_pkg::*; #(
   parameter int DATA_W = 4,
   parameter int ACC_W  = acc_width(4, 8)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic              add_en,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [ACC_W-1:0]  acc_sum
);

   logic [2*DATA_W-1:0] prod;
   logic [ACC_W-1:0]    prod_ext;
   logic [ACC_W-1:0]    acc_q;

`ifdef CONV_SIGNED_EN
   assign prod     = $signed(a) * $signed(b);
   assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
`else
   assign prod     = a * b;
   assign prod_ext = {{(ACC_W-2*DATA_W){1'b0}}, prod};
`endif

   always_comb begin
      acc_sum = acc_q;
      if (clr) begin
         acc_sum = '0;
      end else if (en && add_en) begin
         acc_sum = acc_q + prod_ext;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_sum;
      end
   end

endmodule

// File: rtl/conv_stream_engine.sv
// conv_stream_engine: loads N (x, h) sample pairs over a valid/ready stream, then
// computes the full linear convolution y[k] = sum_i x[i]*h[k-i] with one MAC
// (one product per cycle, N cycles per result) and streams the 2N-1
// full-precision results out with a last flag.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : load handshake, in_x/in_h carry x[i]/h[i]
//   out_valid/out_ready  : result handshake, out_data = y[k], out_last with y[2N-2]
//   busy                 : high while computing or presenting results
// Build option: CONV_SIGNED_EN selects two's complement samples and signed results.
//
// state   | meaning
// LOAD    | accepting sample pairs into x_buf/h_buf, idx counts beats
// COMPUTE | N MAC cycles for y[k], i walks 0..N-1
// OUTPUT  | y[k] held on out_data until the consumer takes it
module conv_stream_engine import conv_pkg::*; #(
   parameter int DATA_W = 4,
   parameter int N      = 8,
   parameter int ACC_W  = acc_width(DATA_W, N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_x,
   input  logic [DATA_W-1:0] in_h,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              out_last,
   output logic              busy
);

   localparam int NUM_OUT = num_out(N);
   localparam int I_W     = $clog2(N);
   localparam int K_W     = $clog2(NUM_OUT);
   localparam logic [I_W-1:0] I_LAST = I_W'(N - 1);
   localparam logic [K_W-1:0] K_LAST = K_W'(NUM_OUT - 1);
   localparam logic [K_W-1:0] J_MAX  = K_W'(N - 1);

   conv_state_e       state;
   logic [I_W-1:0]    idx;
   logic [I_W-1:0]    i;
   logic [K_W-1:0]    k;
   logic [DATA_W-1:0] x_buf [N];
   logic [DATA_W-1:0] h_buf [N];

   logic              load_beat;
   logic [K_W:0]      j;
   logic              tap_hit;
   logic [DATA_W-1:0] x_sel;
   logic [DATA_W-1:0] h_sel;
   logic [ACC_W-1:0]  acc_sum;

   assign in_ready  = (state == LOAD) && !rst;
   assign busy      = (state != LOAD);
   assign load_beat = in_valid && in_ready;

   // j = k - i, one bit wider so a negative difference shows up in the top bit.
   assign j       = {1'b0, k} - {{(K_W+1-I_W){1'b0}}, i};
   assign tap_hit = !j[K_W] && (j[K_W-1:0] <= J_MAX);
   assign x_sel   = x_buf[i];
   assign h_sel   = tap_hit ? h_buf[j[I_W-1:0]] : '0;

   // Buffers are never cleared; every run rewrites all N entries before use.
   always_ff @(posedge clk) begin
      if (load_beat) begin
         x_buf[idx] <= in_x;
         h_buf[idx] <= in_h;
      end
   end

   conv_mac #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .clr     (state != COMPUTE),
      .en      (state == COMPUTE),
      .add_en  (tap_hit),
      .a       (x_sel),
      .b       (h_sel),
      .acc_sum (acc_sum)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LOAD;
         idx       <= '0;
         i         <= '0;
         k         <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (load_beat) begin
                  if (idx == I_LAST) begin
                     idx   <= '0;
                     i     <= '0;
                     k     <= '0;
                     state <= COMPUTE;
                  end else begin
                     idx <= idx + I_W'(1);
                  end
               end
            end
            COMPUTE: begin
               if (i == I_LAST) begin
                  // acc_sum already includes this cycle's product.
                  out_data  <= acc_sum;
                  out_valid <= 1'b1;
                  out_last  <= (k == K_LAST);
                  state     <= OUTPUT;
               end else begin
                  i <= i + I_W'(1);
               end
            end
            OUTPUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  i         <= '0;
                  if (k == K_LAST) begin
                     k     <= '0;
                     idx   <= '0;
                     state <= LOAD;
                  end else begin
                     k     <= k + K_W'(1);
                     state <= COMPUTE;
                  end
               end
            end
            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_stream_engine.sv
// Scoreboard bench for conv_stream_engine: each loaded vector set pushes its
// reference convolution into a queue; a negedge monitor compares every
// presented result against the queue head and pops on handshakes.
module tb_conv_stream_engine;

   localparam int DATA_W  = 4;
   localparam int N       = 8;
   localparam int ACC_W   = conv_pkg::acc_width(DATA_W, N);
   localparam int NUM_OUT = 2 * N - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_x;
   logic [DATA_W-1:0] in_h;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_data;
   logic              out_last;
   logic              busy;

   conv_stream_engine #(.DATA_W(DATA_W), .N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_h      (in_h),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ACC_W-1:0] data;
      logic             last;
   } exp_t;

   exp_t             exp_q [$];
   logic [ACC_W-1:0] got [NUM_OUT];
   int               vec_pop = 0;
   int               checks  = 0;
   int               errors  = 0;
   logic [DATA_W-1:0] xs [N];
   logic [DATA_W-1:0] hs [N];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int sval(input logic [DATA_W-1:0] v);
`ifdef CONV_SIGNED_EN
      return int'($signed(v));
`else
      return int'(v);
`endif
   endfunction

   // Reference: direct sum over the index pairs that land on each output.
   task automatic push_model();
      for (int kk = 0; kk < NUM_OUT; kk++) begin
         int   s;
         exp_t e;
         s = 0;
         for (int ii = 0; ii < N; ii++) begin
            if (kk - ii >= 0 && kk - ii < N) s += sval(xs[ii]) * sval(hs[kk - ii]);
         end
         e.data = ACC_W'(s);
         e.last = (kk == NUM_OUT - 1);
         exp_q.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: actual %0h required no output", out_data);
         end else begin
            check("out_data", 64'(out_data), 64'(exp_q[0].data));
            check("out_last", 64'(out_last), 64'(exp_q[0].last));
            if (out_ready) begin
               if (vec_pop < NUM_OUT) got[vec_pop] = out_data;
               vec_pop++;
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_vec();
      int t = 0;
      while (!in_ready && t < 500) begin
         tick();
         t++;
      end
      check("load_wait_ready", 64'(in_ready), 64'd1);
      push_model();
      vec_pop = 0;
      for (int b = 0; b < N; b++) begin
         in_valid = 1'b1;
         in_x     = xs[b];
         in_h     = hs[b];
         tick();
      end
      in_valid = 1'b0;
      in_x     = '0;
      in_h     = '0;
   endtask

   task automatic expect_latency(input string name);
      for (int c = 1; c <= N; c++) begin
         tick();
         check(name, 64'(out_valid), (c < N) ? 64'd0 : 64'd1);
      end
   endtask

   task automatic drain(input bit rand_ready);
      int t = 0;
      while (exp_q.size() != 0 && t < 4000) begin
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
         tick();
         t++;
      end
      check("drain_left", 64'(exp_q.size()), 64'd0);
      out_ready = 1'b1;
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_in_ready", 64'(in_ready), 64'd1);
   endtask

   task automatic rand_vec();
      for (int b = 0; b < N; b++) begin
         xs[b] = DATA_W'($urandom);
         hs[b] = DATA_W'($urandom);
      end
   endtask

   initial begin
      int t;
      rst = 1'b1; in_valid = 1'b0; in_x = '0; in_h = '0; out_ready = 1'b0;
      repeat (3) tick();
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;

      // Baseline ramp vectors.
      for (int b = 0; b < N; b++) begin
         xs[b] = DATA_W'(b + 1);
         hs[b] = DATA_W'(N - b);
      end
      load_vec();
      expect_latency("first_latency");
      drain(1'b0);
`ifndef CONV_SIGNED_EN
      check("base_y0", 64'(got[0]), 64'd8);
      check("base_y1", 64'(got[1]), 64'd23);
      check("base_y2", 64'(got[2]), 64'd44);
      check("base_y7", 64'(got[7]), 64'd204);
      check("base_y14", 64'(got[14]), 64'd8);
`endif

      // Full-scale samples.
      for (int b = 0; b < N; b++) begin
         xs[b] = '1;
         hs[b] = '1;
      end
      load_vec();
      drain(1'b0);
`ifdef CONV_SIGNED_EN
      check("full_y7", 64'(got[7]), 64'd8);
`else
      check("full_y7", 64'(got[7]), 64'd1800);
`endif

      // Backpressure on y3.
      rand_vec();
      load_vec();
      t = 0;
      while (vec_pop < 3 && t < 500) begin tick(); t++; end
      out_ready = 1'b0;
      t = 0;
      while (!out_valid && t < 500) begin tick(); t++; end
      check("bp_y3_valid", 64'(out_valid), 64'd1);
      for (int c = 0; c < 5; c++) begin
         tick();
         check("bp_hold_valid", 64'(out_valid), 64'd1);
      end
      check("bp_no_skip", 64'(vec_pop), 64'd3);
      out_ready = 1'b1;
      tick();
      check("bp_taken", 64'(vec_pop), 64'd4);
      expect_latency("bp_y4_latency");
      drain(1'b0);

      // Garbage on the input while computing.
      rand_vec();
      load_vec();
      for (int c = 0; c < 6; c++) begin
         in_valid = 1'b1;
         in_x     = DATA_W'($urandom);
         in_h     = DATA_W'($urandom);
         check("gate_in_ready", 64'(in_ready), 64'd0);
         tick();
      end
      in_valid = 1'b0;
      drain(1'b0);
      rand_vec();
      load_vec();
      drain(1'b0);

      // Reset while y5 is computing.
      rand_vec();
      load_vec();
      t = 0;
      while (vec_pop < 5 && t < 500) begin tick(); t++; end
      repeat (3) tick();
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("midrst_in_ready", 64'(in_ready), 64'd0);
      tick();
      rst = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_out_data", 64'(out_data), 64'd0);
      check("midrst_in_ready_after", 64'(in_ready), 64'd1);
      rand_vec();
      load_vec();
      drain(1'b0);

      // Sign-sensitive single-tap vector.
      for (int b = 0; b < N; b++) begin
         xs[b] = '0;
         hs[b] = '0;
      end
      xs[0] = 4'hF;
      hs[0] = 4'h3;
      load_vec();
      drain(1'b0);
`ifdef CONV_SIGNED_EN
      check("sign_y0", 64'(got[0]), 64'h7FD);
`else
      check("sign_y0", 64'(got[0]), 64'h02D);
`endif
      check("sign_y1", 64'(got[1]), 64'd0);

      // Random vectors with random consumer stalls.
      for (int r = 0; r < 4; r++) begin
         rand_vec();
         load_vec();
         drain(1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_stream_engine.md
Name: conv_stream_engine

Overview:
- Parametrised sequential successor to the fixed 8-tap, 4-bit combinational convolution.
- Loads N sample pairs (x[i], h[i]) over a valid/ready stream into internal buffers.
- Computes the full linear convolution, y[k] = sum over i of x[i]*h[k-i], with one MAC unit, one product per cycle.
- Streams the 2N-1 full-precision results out over valid/ready with a last flag; no truncation of results.

Parameters:
- DATA_W, 4, width of each x and h sample.
- N, 8, sequence length of x and of h (N >= 2).
- ACC_W, 2*DATA_W+$clog2(N), result width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  load beat valid.
- in_ready  out  1  engine accepts a load beat.
- in_x  in  DATA_W  sample x[i] for the current beat.
- in_h  in  DATA_W  sample h[i] for the current beat.
- out_valid  out  1  out_data holds y[k].
- out_ready  in  1  consumer accepts y[k].
- out_data  out  ACC_W  convolution result y[k].
- out_last  out  1  high with y[2N-2].
- busy  out  1  high in COMPUTE or OUTPUT.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state=LOAD, load index=0, k=0, i=0, acc=0. out_valid=0, out_data=0, out_last=0, busy=0.
- in_ready = (state==LOAD) & ~rst, so it is 0 while rst is high.
- LOAD:
  - Each in_valid&in_ready edge writes x_buf[idx]=in_x and h_buf[idx]=in_h, then idx++.
  - The edge that accepts beat N-1 moves to COMPUTE with k=0, i=0, acc=0.
- COMPUTE:
  - Exactly N cycles per output, i=0..N-1, with fixed latency regardless of k.
  - If 0 <= k-i <= N-1: acc += x_buf[i]*h_buf[k-i]; otherwise acc is unchanged.
  - The edge with i=N-1 moves to OUTPUT and registers out_data=final acc, out_valid=1, out_last=(k==2N-2).
- OUTPUT:
  - out_data and out_last stay stable while out_valid=1 and out_ready=0.
  - On the handshake edge out_valid drops to 0.
  - If k==2N-2: go to LOAD with idx=0 and k=0.
  - Otherwise: k++, i=0, acc=0, go to COMPUTE.
- Timing:
  - First out_valid rises N cycles after the load-completing edge.
  - Each later result appears N cycles after the previous handshake.
  - Back-to-back throughput is 1 result per N+1 cycles.
- Arithmetic: unsigned by default. Products are 2*DATA_W wide, zero-extended to ACC_W. The accumulator cannot overflow at ACC_W.
- Boundaries:
  - in_valid while not in LOAD is ignored (in_ready=0), and no beat is lost.
  - out_ready high while out_valid=0 has no effect.
  - rst at any point aborts the operation: buffers are treated as empty and outputs return to reset values on that edge.
  - Buffer contents are not cleared; they are always fully rewritten before use.

Optional Feature:
- Macro: CONV_SIGNED_EN.
- Defined: x and h are two's complement. Products are signed, sign-extended to ACC_W, and out_data is signed.
- Undefined: unsigned arithmetic as above.
- Ports, latency and handshake are identical in both builds.

Decomposition:
- Package conv_pkg holds:
  - state enum {LOAD, COMPUTE, OUTPUT};
  - function acc_width(data_w, n) = 2*data_w + $clog2(n);
  - localparam NUM_OUT(n) = 2n-1.
- Sub-module conv_mac: registered multiply-accumulate with clear, enable and add-enable, honouring CONV_SIGNED_EN.
- The top level holds the buffers, counters and FSM.

Test Plan:
- Unsigned baseline: load x=1..8, h=8..1 (N=8, DATA_W=4), out_ready=1 -> 15 results. Check y0=8, y1=23, y2=44, y7=204, y14=8. out_last only on y14. First out_valid exactly 8 cycles after the last load edge.
- Full-scale: x=h=15 for all 8 taps -> y7=1800, with no overflow at 11 bits.
- Backpressure: hold out_ready=0 for 5 cycles when y3 is presented -> out_valid stays 1, out_data and out_last stable, no result skipped, y4 follows 8 cycles after the handshake.
- Input gating: drive in_valid=1 with garbage during COMPUTE -> in_ready=0, results unchanged. Afterwards a second vector set loads cleanly.
- Mid-operation reset: assert rst for 1 cycle while y5 is computing -> out_valid=0 and busy=0 next cycle, in_ready=1 after rst drops. A fresh load yields correct y0.
- Signed build (CONV_SIGNED_EN): x0=4'hF (-1), h0=3, all other samples 0 -> y0=11'h7FD (-3), all other results 0. The unsigned build gives y0=11'h02D.
